// File: rtl/shift_unit_ctrl.sv
// Two-requester front end that sequences an external 32-bit logical barrel shifter
// through one or two passes to produce SLL/SRL/SRA (and ROL/ROR when SHIFT_ROTATE_EN is defined).
module shift_unit_ctrl #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_shamt,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_shamt,
  input  logic [2:0]  req1_op,
  output logic [31:0] sh_in,
  output logic [4:0]  sh_shamt,
  output logic        sh_dir,
  input  logic [31:0] sh_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id,
  output logic        rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_RESP} state_t;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  state_t      state;
  logic        prio;
  logic [31:0] data_q;
  logic [4:0]  shamt_q;
  logic [2:0]  op_q;
  logic        id_q;
  logic [31:0] acc;

  logic        grant_valid;
  logic        grant_id;
  logic        both_valid;
  logic [31:0] sel_data;
  logic [4:0]  sel_shamt;
  logic [2:0]  sel_op;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_SLL, OP_SRL, OP_SRA: op_legal = 1'b1;
`ifdef SHIFT_ROTATE_EN
      OP_ROL, OP_ROR:         op_legal = 1'b1;
`endif
      default:                op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic needs_pass2(input logic [2:0] op);
    case (op)
      OP_SRA:         needs_pass2 = 1'b1;
`ifdef SHIFT_ROTATE_EN
      OP_ROL, OP_ROR: needs_pass2 = 1'b1;
`endif
      default:        needs_pass2 = 1'b0;
    endcase
  endfunction

  function automatic logic dir_left(input logic [2:0] op);
    dir_left = (op == OP_SLL) || (op == OP_ROL);
  endfunction

  always_comb begin
    both_valid  = req0_valid && req1_valid;
    grant_valid = req0_valid || req1_valid;
    if (both_valid) begin
      grant_id = prio;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end else begin
      grant_id = 1'b0;
    end
    if (grant_id) begin
      sel_data  = req1_data;
      sel_shamt = req1_shamt;
      sel_op    = req1_op;
    end else begin
      sel_data  = req0_data;
      sel_shamt = req0_shamt;
      sel_op    = req0_op;
    end
  end

  // Ready is masked by rst_n so both stay low while reset is held.
  assign req0_ready = rst_n && (state == S_IDLE) && grant_valid && !grant_id;
  assign req1_ready = rst_n && (state == S_IDLE) && grant_valid &&  grant_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      prio      <= RR_INIT;
      data_q    <= 32'd0;
      shamt_q   <= 5'd0;
      op_q      <= 3'd0;
      id_q      <= 1'b0;
      acc       <= 32'd0;
      sh_in     <= 32'd0;
      sh_shamt  <= 5'd0;
      sh_dir    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            data_q  <= sel_data;
            shamt_q <= sel_shamt;
            op_q    <= sel_op;
            id_q    <= grant_id;
            if (both_valid) begin
              prio <= ~prio;
            end
            if (op_legal(sel_op)) begin
              state    <= S_PASS1;
              sh_in    <= sel_data;
              sh_shamt <= sel_shamt;
              sh_dir   <= dir_left(sel_op);
            end else begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= 32'd0;
              rsp_id    <= grant_id;
              rsp_err   <= 1'b1;
            end
          end
        end
        S_PASS1: begin
          acc <= sh_out;
          if (needs_pass2(op_q)) begin
            state <= S_PASS2;
`ifdef SHIFT_ROTATE_EN
            if (op_q == OP_SRA) begin
              sh_in    <= 32'hFFFF_FFFF;
              sh_shamt <= shamt_q;
              sh_dir   <= 1'b0;
            end else begin
              // 5-bit wrap makes shamt=0 a zero-distance second pass.
              sh_in    <= data_q;
              sh_shamt <= 5'd0 - shamt_q;
              sh_dir   <= ~sh_dir;
            end
`else
            sh_in    <= 32'hFFFF_FFFF;
            sh_shamt <= shamt_q;
            sh_dir   <= 1'b0;
`endif
          end else begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= sh_out;
            rsp_id    <= id_q;
            rsp_err   <= 1'b0;
            sh_in     <= 32'd0;
            sh_shamt  <= 5'd0;
            sh_dir    <= 1'b0;
          end
        end
        S_PASS2: begin
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_err   <= 1'b0;
          sh_in     <= 32'd0;
          sh_shamt  <= 5'd0;
          sh_dir    <= 1'b0;
          // Sign fill: inverted all-ones shift supplies the vacated high bits.
          if (op_q == OP_SRA) begin
            rsp_data <= data_q[31] ? (acc | ~sh_out) : acc;
          end else begin
            rsp_data <= acc | sh_out;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_ctrl.sv
// Directed self-checking bench for shift_unit_ctrl with a behavioural logical barrel shifter.
module tb_shift_unit_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_data;
  logic [4:0]  req0_shamt;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_data;
  logic [4:0]  req1_shamt;
  logic [2:0]  req1_op;
  logic [31:0] sh_in;
  logic [4:0]  sh_shamt;
  logic        sh_dir;
  logic [31:0] sh_out;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id, rsp_err;

  int total = 0;
  int bad   = 0;

  shift_unit_ctrl #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .sh_in(sh_in), .sh_shamt(sh_shamt), .sh_dir(sh_dir), .sh_out(sh_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  assign sh_out = sh_dir ? (sh_in << sh_shamt) : (sh_in >> sh_shamt);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic id, input logic [31:0] d, input logic [4:0] s,
                        input logic [2:0] op);
    if (id) begin
      req1_valid = 1'b1; req1_data = d; req1_shamt = s; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_shamt = s; req0_op = op;
    end
    #1;
    chk("ready0", {31'd0, req0_ready}, {31'd0, !id});
    chk("ready1", {31'd0, req1_ready}, {31'd0, id});
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      step();
      lat++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input int lat, input int exp_lat,
                           input logic [31:0] exp_data, input logic exp_id, input logic exp_err);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_data"}, rsp_data, exp_data);
    chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, exp_id});
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
  endtask

  initial begin
    int lat;
    logic seen;
    logic [31:0] held;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 32'd0; req0_shamt = 5'd0; req0_op = 3'd0;
    req1_valid = 1'b0; req1_data = 32'd0; req1_shamt = 5'd0; req1_op = 3'd0;
    #2;
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_sh_in", sh_in, 32'd0);
    req0_valid = 1'b0;
    #10 rst_n = 1'b1;
    step();

    // SLL 1 << 31 on requester 0
    accept(1'b0, 32'h0000_0001, 5'd31, 3'b000);
    chk("sll_sh_in", sh_in, 32'h0000_0001);
    chk("sll_sh_shamt", {27'd0, sh_shamt}, 32'd31);
    chk("sll_sh_dir", {31'd0, sh_dir}, 32'd1);
    wait_rsp(lat);
    check_rsp("sll", lat, 2, 32'h8000_0000, 1'b0, 1'b0);
    finish_rsp();
    chk("idle_after_sll", {31'd0, rsp_valid}, 32'd0);
    chk("idle_sh_in", sh_in, 32'd0);

    // SRA negative and positive on requester 1
    accept(1'b1, 32'h8000_0000, 5'd4, 3'b010);
    wait_rsp(lat);
    check_rsp("sra_neg", lat, 3, 32'hF800_0000, 1'b1, 1'b0);
    finish_rsp();
    accept(1'b1, 32'h4000_0000, 5'd4, 3'b010);
    wait_rsp(lat);
    check_rsp("sra_pos", lat, 3, 32'h0400_0000, 1'b1, 1'b0);
    finish_rsp();

    // SRL, then illegal op 101
    accept(1'b0, 32'hF000_000F, 5'd8, 3'b001);
    wait_rsp(lat);
    check_rsp("srl", lat, 2, 32'h00F0_0000, 1'b0, 1'b0);
    finish_rsp();
    accept(1'b0, 32'h1234_5678, 5'd3, 3'b101);
    chk("ill_sh_in", sh_in, 32'd0);
    wait_rsp(lat);
    check_rsp("illegal", lat, 1, 32'd0, 1'b0, 1'b1);
    finish_rsp();

    // Rotates: legal only when the rotate option is built in
    accept(1'b0, 32'h0000_00FF, 5'd8, 3'b100);
    wait_rsp(lat);
`ifdef SHIFT_ROTATE_EN
    check_rsp("ror", lat, 3, 32'hFF00_0000, 1'b0, 1'b0);
`else
    check_rsp("ror", lat, 1, 32'd0, 1'b0, 1'b1);
`endif
    finish_rsp();
    accept(1'b1, 32'h1234_5678, 5'd0, 3'b011);
    wait_rsp(lat);
`ifdef SHIFT_ROTATE_EN
    check_rsp("rol0", lat, 3, 32'h1234_5678, 1'b1, 1'b0);
`else
    check_rsp("rol0", lat, 1, 32'd0, 1'b1, 1'b1);
`endif
    finish_rsp();

    // Backpressure: response held 5 cycles, no ready while busy
    accept(1'b0, 32'h0000_0003, 5'd1, 3'b000);
    wait_rsp(lat);
    check_rsp("stall", lat, 2, 32'h0000_0006, 1'b0, 1'b0);
    req0_valid = 1'b1;
    held = rsp_data;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!rsp_valid || rsp_data !== held || req0_ready) seen = 1'b1;
    end
    chk("stall_stable", {31'd0, seen}, 32'd0);
    rsp_ready = 1'b1;
    #1;
    chk("no_ready_at_handshake", {31'd0, req0_ready}, 32'd0);
    step();
    rsp_ready = 1'b0;
    req0_valid = 1'b0;
    chk("stall_done", {31'd0, rsp_valid}, 32'd0);

    // Reset asserted during PASS2 of an SRA
    accept(1'b1, 32'h8000_0000, 5'd4, 3'b010);
    step();
    chk("p2_sh_in", sh_in, 32'hFFFF_FFFF);
    chk("p2_sh_dir", {31'd0, sh_dir}, 32'd0);
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sh_in", sh_in, 32'd0);
    chk("mid_rst_sh_shamt", {27'd0, sh_shamt}, 32'd0);
    chk("mid_rst_ready1", {31'd0, req1_ready}, 32'd0);
    chk("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req1_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_rst", {31'd0, seen}, 32'd0);

    // Round robin with both requesters continuously valid
    req0_valid = 1'b1; req0_data = 32'h0000_0011; req0_shamt = 5'd1; req0_op = 3'b000;
    req1_valid = 1'b1; req1_data = 32'h0000_0100; req1_shamt = 5'd4; req1_op = 3'b001;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ready1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      wait_rsp(lat);
      check_rsp("rr", lat, 2, (i % 2 == 0) ? 32'h0000_0022 : 32'h0000_0010,
                (i % 2 == 1), 1'b0);
      finish_rsp();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
